// File: rtl/maze_pkg.sv
// Shared encodings for the maze game: screen states seen by the renderer,
// move directions and the control FSM states.
package maze_pkg;
    localparam logic [1:0] ST_WELCOME = 2'd0;
    localparam logic [1:0] ST_MAP     = 2'd1;
    localparam logic [1:0] ST_WIN     = 2'd2;

    localparam int MAX_NUM  = 19;
    localparam int MAP_BITS = MAX_NUM * MAX_NUM;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        FSM_WELCOME = 2'd0,
        FSM_PLAY    = 2'd1,
        FSM_CHECK   = 2'd2,
        FSM_WIN     = 2'd3
    } fsm_t;
endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector: `rise` is high for one cycle after each low-to-high
// transition of the matching `btn` bit, so a held button gives one request.
module btn_edge #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] btn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn;
        end
    end

    assign rise = btn & ~btn_q;
endmodule

// File: rtl/maze_player_ctrl.sv
// Maze game control: screen FSM, player position and wall-checked moves.
// Defining MAZE_STEP_COUNT_EN adds a saturating committed-move counter on `steps`.
module maze_player_ctrl #(
    parameter int START_X = 1,
    parameter int START_Y = 1,
    parameter int MAX_NUM = 19,
    parameter int MIN_NUM = 5
) (
    input  logic                       vga_clk,
    input  logic                       rst_sys,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_left,
    input  logic                       btn_right,
    input  logic                       btn_start,
    input  logic [4:0]                 num,
    input  logic [MAX_NUM*MAX_NUM-1:0] map,
    output logic [1:0]                 state,
    output logic [4:0]                 x_index,
    output logic [4:0]                 y_index,
    output logic                       move_reject,
    output logic                       win_pulse
`ifdef MAZE_STEP_COUNT_EN
    ,
    output logic [9:0]                 steps
`endif
);
    import maze_pkg::*;

    logic [4:0] rise;
    fsm_t       fsm_q;
    logic [4:0] side_q;
    logic [4:0] tx_q;
    logic [4:0] ty_q;
    dir_t       dir;
    logic       dir_req;
    logic [4:0] tgt_x;
    logic [4:0] tgt_y;
    logic       tgt_ok;
    logic [8:0] idx;
    logic       road;
    logic       at_goal;
    logic       start_ok;

    // Bit order: {start, right, left, down, up}
    btn_edge #(.WIDTH(5)) u_btn_edge (
        .clk  (vga_clk),
        .rst  (rst_sys),
        .btn  ({btn_start, btn_right, btn_left, btn_down, btn_up}),
        .rise (rise)
    );

    // Pick one direction (up > down > left > right) and bound-check its target.
    always_comb begin
        dir_req = |rise[3:0];
        dir     = DIR_RIGHT;
        if (rise[0]) begin
            dir = DIR_UP;
        end else if (rise[1]) begin
            dir = DIR_DOWN;
        end else if (rise[2]) begin
            dir = DIR_LEFT;
        end
        tgt_x  = x_index;
        tgt_y  = y_index;
        tgt_ok = 1'b1;
        case (dir)
            DIR_UP: begin
                tgt_ok = (y_index != 5'd0);
                tgt_y  = y_index - 5'd1;
            end
            DIR_DOWN: begin
                tgt_ok = ((y_index + 5'd1) < side_q);
                tgt_y  = y_index + 5'd1;
            end
            DIR_LEFT: begin
                tgt_ok = (x_index != 5'd0);
                tgt_x  = x_index - 5'd1;
            end
            DIR_RIGHT: begin
                tgt_ok = ((x_index + 5'd1) < side_q);
                tgt_x  = x_index + 5'd1;
            end
            default: ;
        endcase
    end

    assign idx      = {4'd0, ty_q} * {4'd0, side_q} + {4'd0, tx_q};
    assign road     = map[idx];
    assign at_goal  = (tx_q == side_q - 5'd2) && (ty_q == side_q - 5'd2);
    assign start_ok = rise[4] && (num >= 5'(MIN_NUM)) && (num <= 5'(MAX_NUM));

    always_ff @(posedge vga_clk or posedge rst_sys) begin
        if (rst_sys) begin
            fsm_q       <= FSM_WELCOME;
            state       <= ST_WELCOME;
            x_index     <= 5'(START_X);
            y_index     <= 5'(START_Y);
            side_q      <= 5'd0;
            tx_q        <= 5'd0;
            ty_q        <= 5'd0;
            move_reject <= 1'b0;
            win_pulse   <= 1'b0;
`ifdef MAZE_STEP_COUNT_EN
            steps       <= 10'd0;
`endif
        end else begin
            move_reject <= 1'b0;
            win_pulse   <= 1'b0;
            case (fsm_q)
                FSM_WELCOME: begin
                    if (start_ok) begin
                        side_q  <= num;
                        x_index <= 5'(START_X);
                        y_index <= 5'(START_Y);
                        fsm_q   <= FSM_PLAY;
                        state   <= ST_MAP;
`ifdef MAZE_STEP_COUNT_EN
                        steps   <= 10'd0;
`endif
                    end
                end
                FSM_PLAY: begin
                    if (dir_req) begin
                        if (tgt_ok) begin
                            tx_q  <= tgt_x;
                            ty_q  <= tgt_y;
                            fsm_q <= FSM_CHECK;
                        end else begin
                            move_reject <= 1'b1;
                        end
                    end
                end
                // Edges arriving here are dropped; the map is only sampled now.
                FSM_CHECK: begin
                    if (road) begin
                        x_index <= tx_q;
                        y_index <= ty_q;
`ifdef MAZE_STEP_COUNT_EN
                        if (steps != 10'd1023) begin
                            steps <= steps + 10'd1;
                        end
`endif
                        if (at_goal) begin
                            fsm_q     <= FSM_WIN;
                            state     <= ST_WIN;
                            win_pulse <= 1'b1;
                        end else begin
                            fsm_q <= FSM_PLAY;
                        end
                    end else begin
                        move_reject <= 1'b1;
                        fsm_q       <= FSM_PLAY;
                    end
                end
                FSM_WIN: begin
                    if (rise[4]) begin
                        fsm_q   <= FSM_WELCOME;
                        state   <= ST_WELCOME;
                        x_index <= 5'(START_X);
                        y_index <= 5'(START_Y);
                    end
                end
                default: begin
                    fsm_q <= FSM_WELCOME;
                    state <= ST_WELCOME;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_maze_player_ctrl.sv
// Self-checking bench for maze_player_ctrl: directed sequences, a vector
// table on a walled 7x7 maze, and random presses against a rule-level model.
module tb_maze_player_ctrl;
    logic         vga_clk = 1'b0;
    logic         rst_sys;
    logic         btn_up, btn_down, btn_left, btn_right, btn_start;
    logic [4:0]   num;
    logic [360:0] map;
    logic [1:0]   state;
    logic [4:0]   x_index, y_index;
    logic         move_reject, win_pulse;
`ifdef MAZE_STEP_COUNT_EN
    logic [9:0]   steps;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Rule-level model of the game: screen 0/1/2, position, latched side.
    int m_screen, m_x, m_y, m_side, m_steps, exp_rej, exp_win;

    typedef struct {
        logic [4:0] mask;
        int         ex;
        int         ey;
        int         erej;
    } vec_t;
    vec_t vecs[15];

    maze_player_ctrl dut (
        .vga_clk     (vga_clk),
        .rst_sys     (rst_sys),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_start   (btn_start),
        .num         (num),
        .map         (map),
        .state       (state),
        .x_index     (x_index),
        .y_index     (y_index),
        .move_reject (move_reject),
        .win_pulse   (win_pulse)
`ifdef MAZE_STEP_COUNT_EN
        ,
        .steps       (steps)
`endif
    );

    always #5 vga_clk = ~vga_clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic setButtons(input logic [4:0] mask);
        {btn_start, btn_right, btn_left, btn_down, btn_up} = mask;
    endtask

    // One press: buttons high for one cycle, then released; pulses are
    // counted over the two cycles it takes a move to resolve.
    task automatic applyStimulus(input logic [4:0] mask, output int rej, output int win);
        setButtons(mask);
        tick();
        rej = int'(move_reject);
        win = int'(win_pulse);
        setButtons(5'b0);
        tick();
        rej += int'(move_reject);
        win += int'(win_pulse);
    endtask

    task automatic doReset();
        rst_sys = 1'b1;
        tick();
        tick();
        rst_sys = 1'b0;
        tick();
    endtask

    task automatic modelStep(input logic [4:0] mask, input int n);
        int tx, ty;
        exp_rej = 0;
        exp_win = 0;
        tx = m_x;
        ty = m_y;
        if (m_screen == 0) begin
            if (mask[4] && n >= 5 && n <= 19) begin
                m_screen = 1;
                m_side   = n;
                m_x      = 1;
                m_y      = 1;
                m_steps  = 0;
            end
        end else if (m_screen == 1) begin
            if (mask[3:0] != 4'b0) begin
                if (mask[0]) ty = ty - 1;
                else if (mask[1]) ty = ty + 1;
                else if (mask[2]) tx = tx - 1;
                else tx = tx + 1;
                if (tx < 0 || ty < 0 || tx >= m_side || ty >= m_side) begin
                    exp_rej = 1;
                end else if (map[ty * m_side + tx]) begin
                    m_x = tx;
                    m_y = ty;
                    if (m_steps < 1023) m_steps++;
                    if (tx == m_side - 2 && ty == m_side - 2) begin
                        m_screen = 2;
                        exp_win  = 1;
                    end
                end else begin
                    exp_rej = 1;
                end
            end
        end else begin
            if (mask[4]) begin
                m_screen = 0;
                m_x      = 1;
                m_y      = 1;
            end
        end
    endtask

    initial begin
        int rej, win, rej_sum, win_sum;
        logic [4:0] mask;

        rst_sys = 1'b1;
        setButtons(5'b0);
        num = 5'd0;
        map = '1;
        tick();
        tick();
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_x", int'(x_index), 1);
        checkOutput("reset_y", int'(y_index), 1);
        checkOutput("reset_reject", int'(move_reject), 0);
        checkOutput("reset_win", int'(win_pulse), 0);
        rst_sys = 1'b0;
        tick();

        // Too-small maze is refused, a legal one starts the game.
        num = 5'd3;
        applyStimulus(5'b10000, rej, win);
        checkOutput("start_small_state", int'(state), 0);
        num = 5'd7;
        applyStimulus(5'b10000, rej, win);
        checkOutput("start_state", int'(state), 1);
        checkOutput("start_x", int'(x_index), 1);
        checkOutput("start_y", int'(y_index), 1);

        // Held right: position moves after two cycles and only once.
        setButtons(5'b01000);
        tick();
        checkOutput("latency_n1_x", int'(x_index), 1);
        tick();
        checkOutput("latency_n2_x", int'(x_index), 2);
        checkOutput("latency_n2_y", int'(y_index), 1);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("hold_x", int'(x_index), 2);
        setButtons(5'b0);
        tick();

        // A down edge during the check cycle is dropped.
        setButtons(5'b01000);
        tick();
        setButtons(5'b00010);
        tick();
        tick();
        tick();
        setButtons(5'b0);
        tick();
        checkOutput("drop_x", int'(x_index), 3);
        checkOutput("drop_y", int'(y_index), 1);

        // Vector table on a 7x7 maze with walls at (2,1) and (1,4).
        vecs[0]  = '{5'b01000, 1, 1, 1};
        vecs[1]  = '{5'b00010, 1, 2, 0};
        vecs[2]  = '{5'b01001, 1, 1, 0};
        vecs[3]  = '{5'b00100, 0, 1, 0};
        vecs[4]  = '{5'b00100, 0, 1, 1};
        vecs[5]  = '{5'b00001, 0, 0, 0};
        vecs[6]  = '{5'b00001, 0, 0, 1};
        vecs[7]  = '{5'b00010, 0, 1, 0};
        vecs[8]  = '{5'b00010, 0, 2, 0};
        vecs[9]  = '{5'b00010, 0, 3, 0};
        vecs[10] = '{5'b00100, 0, 3, 1};
        vecs[11] = '{5'b01000, 1, 3, 0};
        vecs[12] = '{5'b00010, 1, 3, 1};
        vecs[13] = '{5'b01110, 1, 3, 1};
        vecs[14] = '{5'b01100, 0, 3, 0};
        doReset();
        map = '1;
        map[1*7+2] = 1'b0;
        map[4*7+1] = 1'b0;
        num = 5'd7;
        applyStimulus(5'b10000, rej, win);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].mask, rej, win);
            checkOutput($sformatf("vec%0d_x", i), int'(x_index), vecs[i].ex);
            checkOutput($sformatf("vec%0d_y", i), int'(y_index), vecs[i].ey);
            checkOutput($sformatf("vec%0d_reject", i), rej, vecs[i].erej);
            checkOutput($sformatf("vec%0d_state", i), int'(state), 1);
`ifdef MAZE_STEP_COUNT_EN
            if (i == 5) checkOutput("steps_after_4", int'(steps), 4);
`endif
        end
`ifdef MAZE_STEP_COUNT_EN
        checkOutput("steps_table_end", int'(steps), 9);
`endif

        // Walk an open 7x7 maze to (5,5), then confirm the win screen.
        doReset();
        map = '1;
        num = 5'd7;
        applyStimulus(5'b10000, rej, win);
        win_sum = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(5'b01000, rej, win);
            win_sum += win;
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'b00010, rej, win);
            win_sum += win;
        end
        checkOutput("prewin_pulses", win_sum, 0);
        checkOutput("prewin_state", int'(state), 1);
        applyStimulus(5'b00010, rej, win);
        checkOutput("win_pulse", win, 1);
        checkOutput("win_state", int'(state), 2);
        checkOutput("win_x", int'(x_index), 5);
        checkOutput("win_y", int'(y_index), 5);
        tick();
        checkOutput("win_pulse_gone", int'(win_pulse), 0);
        applyStimulus(5'b00001, rej, win);
        checkOutput("win_ignore_y", int'(y_index), 5);
        checkOutput("win_ignore_state", int'(state), 2);
`ifdef MAZE_STEP_COUNT_EN
        checkOutput("win_steps", int'(steps), 8);
`endif
        applyStimulus(5'b10000, rej, win);
        checkOutput("restart_state", int'(state), 0);
        checkOutput("restart_x", int'(x_index), 1);
        checkOutput("restart_y", int'(y_index), 1);

        // Reset mid-check: async clear, no late commit after release.
        num = 5'd7;
        applyStimulus(5'b10000, rej, win);
        applyStimulus(5'b01000, rej, win);
        setButtons(5'b01000);
        tick();
        setButtons(5'b0);
        #2;
        rst_sys = 1'b1;
        #1;
        checkOutput("async_rst_state", int'(state), 0);
        checkOutput("async_rst_x", int'(x_index), 1);
        checkOutput("async_rst_y", int'(y_index), 1);
        tick();
        tick();
        rst_sys = 1'b0;
        tick();
        tick();
        checkOutput("post_rst_state", int'(state), 0);
        checkOutput("post_rst_x", int'(x_index), 1);
        checkOutput("post_rst_reject", int'(move_reject), 0);

        // Random presses against the model on a random sparse-wall map.
        doReset();
        for (int i = 0; i < 361; i++) map[i] = ($urandom_range(0, 6) != 0);
        m_screen = 0;
        m_x      = 1;
        m_y      = 1;
        m_side   = 0;
        m_steps  = 0;
        for (int i = 0; i < 400; i++) begin
            mask[3:0] = 4'($urandom_range(0, 15));
            mask[4]   = ($urandom_range(0, 5) == 0);
            num       = 5'($urandom_range(3, 8));
            modelStep(mask, int'(num));
            applyStimulus(mask, rej_sum, win_sum);
            checkOutput("rand_state", int'(state), m_screen);
            checkOutput("rand_x", int'(x_index), m_x);
            checkOutput("rand_y", int'(y_index), m_y);
            checkOutput("rand_reject", rej_sum, exp_rej);
            checkOutput("rand_win", win_sum, exp_win);
`ifdef MAZE_STEP_COUNT_EN
            if (m_screen != 0) checkOutput("rand_steps", int'(steps), m_steps);
`endif
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
